ped_request_ctl: RTL and testbench
==================================

// Module: ped_request_ctl
// PURPOSE
//  Pedestrian-crossing front end that sits directly upstream of the light sequencer (ryg_ctl).
//  Debounces the crossing push-button and latches a request, then raises ped_req toward the sequencer.
//  When the sequencer answers with ped_grant (vehicle light 1 held red), the block runs the walk phase:
//  steady walk, then flashing walk, with a seconds countdown for the 7-seg count logic. Runs on clk_fst.
// PARAMETERS
//  DEB_LEN     4   consecutive equal clk_fst samples needed to accept a button level change
//  WALK_TIME   10  steady-walk duration, in ticks of clk_cnt_dn
//  FLASH_TIME  5   flashing-walk duration, in ticks; must be >= 1
//  CNT_W       8   width of walk_cnt, binary
// PORTS
//  clk_fst        in   1      block clock
//  rst            in   1      reset, asynchronous, active-high
//  day_night      in   1      1 = day (normal operation), 0 = night (block disabled)
//  clk_cnt_dn     in   1      slow count-down clock; sampled as data, never used as a clock
//  btn_raw        in   1      crossing push-button, async, active-high, bouncy
//  ped_grant      in   1      from sequencer: 1 = crossing is safe (vehicle red)
//  ped_req        out  1      to sequencer: crossing phase requested/in use
//  walk_led       out  1      walk lamp
//  dont_walk_led  out  1      don't-walk lamp
//  walk_cnt       out  CNT_W  remaining walk seconds (binary); 0 when not walking
//  req_pending    out  1      request latched and not yet served (indicator LED)
// BEHAVIOUR
//  Reset (async): state=IDLE; ped_req=0, walk_led=0, dont_walk_led=1, walk_cnt=0, req_pending=0;
//   sync/debounce flops cleared, debounced button=0.
//  Input conditioning: btn_raw, clk_cnt_dn, ped_grant each pass a 2-flop synchroniser.
//   tick = 1-cycle pulse on a 0->1 edge of the synchronised clk_cnt_dn.
//   Debounce: the level is accepted after DEB_LEN consecutive equal samples. press = 1-cycle pulse
//   on a 0->1 edge of the debounced level.
//   Latency from a clean btn_raw rise to press is 2 + DEB_LEN cycles.
//  FSM, one transition per clk_fst:
//   IDLE:  dont_walk=1. press -> PENDING.
//   PENDING: ped_req=1, req_pending=1.
//     If ped_grant=1 -> WALK, loading walk_cnt = WALK_TIME+FLASH_TIME and clearing req_pending.
//   WALK:  walk_led=1, dont_walk=0. Each tick decrements walk_cnt.
//     When walk_cnt reaches FLASH_TIME -> FLASH.
//   FLASH: walk_led = synchronised clk_cnt_dn level, dont_walk=0. Each tick decrements walk_cnt.
//     When walk_cnt reaches 0 -> CLEAR.
//   CLEAR: ped_req=0, walk_led=0, dont_walk=1, walk_cnt=0.
//     Once ped_grant=0 -> PENDING if req_pending=1, else IDLE.
//  Handshake:
//   - ped_req rises only in PENDING and stays high through WALK/FLASH.
//   - ped_req falls only on entering CLEAR (or at night/reset).
//   - The sequencer must hold ped_grant until ped_req falls.
//  Boundary cases:
//   - ped_grant drops during WALK/FLASH (abort): go to CLEAR next cycle, walk_cnt=0, dont_walk=1.
//   - press during WALK/FLASH is ignored; press during CLEAR sets req_pending and re-arms the request.
//   - press in PENDING: no effect (already latched).
//   - tick and a state exit on the same cycle: the exit wins, and no decrement is applied after the exit.
//   - walk_cnt never underflows: decrements are gated to walk_cnt>0.
//   - WALK_TIME=0: the WALK state is skipped; PENDING goes directly to FLASH.
//   - day_night=0 (any state, next cycle): state=IDLE, req_pending=0, ped_req=0, walk_cnt=0,
//     walk_led=0, dont_walk_led = synchronised clk_cnt_dn (flashing). Presses are ignored.
//   - Returning to day resumes in IDLE.
//   - rst mid-phase: immediate return to the reset values; the sequencer sees ped_req drop asynchronously.
// STRUCTURE
//  Shared traffic constants include (traffic_defs.vh):
//   - FSM state encodings PED_IDLE/PENDING/WALK/FLASH/CLEAR (3-bit)
//   - default WALK_TIME/FLASH_TIME
//  One sub-module, btn_debounce:
//   - parameter DEB_LEN; ports clk, rst, din, level, rise
//   - contains the synchroniser, the stability counter and the edge detector
//  The tick and ped_grant synchronisers and the FSM stay in the top module.
// TESTING
//  1 Reset: assert rst mid-WALK
//    -> ped_req=0, walk_led=0, dont_walk_led=1, walk_cnt=0, state IDLE in the same cycle.
//  2 Bounce: btn_raw toggles 1/0 every clk_fst for 6 cycles, then holds 1
//    -> exactly one press, 6 cycles after the hold starts; ped_req=1.
//  3 Full cycle: press, ped_grant=1 3 cycles later
//    -> walk_cnt=15, WALK for 10 ticks (cnt 15..6), FLASH for 5 ticks (cnt 5..1, walk_led follows clk_cnt_dn),
//       cnt=0 then CLEAR; ped_req falls; ped_grant=0 -> IDLE.
//  4 Abort: ped_grant falls at walk_cnt=8
//    -> next cycle CLEAR, walk_cnt=0, dont_walk_led=1, ped_req=0.
//  5 Re-arm: press during FLASH ignored; press during CLEAR
//    -> req_pending=1; after ped_grant=0, back to PENDING with ped_req=1.
//  6 Night: day_night=0 while PENDING
//    -> IDLE, req_pending=0, dont_walk_led tracks clk_cnt_dn; a press at night gives no ped_req after returning to day.

Source files
------------

// File: rtl/ped_request_ctl_pkg.sv
// Shared constants, FSM encoding and lamp decode for the pedestrian request controller.
package ped_request_ctl_pkg;

  localparam int unsigned DefDebLen    = 4;
  localparam int unsigned DefWalkTime  = 10;
  localparam int unsigned DefFlashTime = 5;
  localparam int unsigned DefCntW      = 8;

  typedef enum logic [2:0] {
    PedIdle    = 3'd0,
    PedPending = 3'd1,
    PedWalk    = 3'd2,
    PedFlash   = 3'd3,
    PedClear   = 3'd4
  } ped_state_e;

  typedef struct packed {
    logic ped_req;
    logic walk_led;
    logic dont_walk_led;
  } lamp_t;

  localparam lamp_t LampsOff = '{ped_req: 1'b0, walk_led: 1'b0, dont_walk_led: 1'b1};

  // Lamp and request levels for the state being entered; blink is the synchronised slow clock.
  function automatic lamp_t lamps_for(ped_state_e st, logic day, logic blink);
    lamp_t l;
    l = LampsOff;
    if (!day) begin
      l.dont_walk_led = blink;
    end else begin
      unique case (st)
        PedPending: l.ped_req = 1'b1;
        PedWalk: begin
          l.ped_req       = 1'b1;
          l.walk_led      = 1'b1;
          l.dont_walk_led = 1'b0;
        end
        PedFlash: begin
          l.ped_req       = 1'b1;
          l.walk_led      = blink;
          l.dont_walk_led = 1'b0;
        end
        default: ;
      endcase
    end
    return l;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEB_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEB_LEN + 1);

  logic [1:0]      sync_q;
  logic            level_q;
  logic            level_dly_q;
  logic [CntW-1:0] stab_q;

  // stab_q counts consecutive synchronised samples that disagree with the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      stab_q      <= '0;
    end else begin
      sync_q      <= {sync_q[0], din};
      level_dly_q <= level_q;
      if (sync_q[1] == level_q) begin
        stab_q <= '0;
      end else if (stab_q == CntW'(DEB_LEN - 1)) begin
        level_q <= sync_q[1];
        stab_q  <= '0;
      end else begin
        stab_q <= stab_q + CntW'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_dly_q;

endmodule

// File: rtl/ped_request_ctl.sv
// Pedestrian crossing front end: latches a debounced request, handshakes with the light
// sequencer and runs the steady/flashing walk phase with a seconds countdown.
module ped_request_ctl
  import ped_request_ctl_pkg::*;
#(
  parameter int unsigned DEB_LEN    = DefDebLen,
  parameter int unsigned WALK_TIME  = DefWalkTime,
  parameter int unsigned FLASH_TIME = DefFlashTime,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic             clk_fst,
  input  logic             rst,
  input  logic             day_night,
  input  logic             clk_cnt_dn,
  input  logic             btn_raw,
  input  logic             ped_grant,
  output logic             ped_req,
  output logic             walk_led,
  output logic             dont_walk_led,
  output logic [CNT_W-1:0] walk_cnt,
  output logic             req_pending
);

  localparam logic [CNT_W-1:0] LoadCnt  = CNT_W'(WALK_TIME + FLASH_TIME);
  localparam logic [CNT_W-1:0] FlashCnt = CNT_W'(FLASH_TIME);

  logic [2:0]       cdn_q;
  logic [1:0]       grant_q;
  logic             cdn_s, tick, grant_s;
  logic             btn_level, btn_rise, press;
  ped_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             pend_q, pend_d;
  lamp_t            lamp_q;

  btn_debounce #(
    .DEB_LEN(DEB_LEN)
  ) u_btn_debounce (
    .clk  (clk_fst),
    .rst  (rst),
    .din  (btn_raw),
    .level(btn_level),
    .rise (btn_rise)
  );

  assign press   = btn_rise & btn_level;
  assign cdn_s   = cdn_q[1];
  assign tick    = cdn_q[1] & ~cdn_q[2];
  assign grant_s = grant_q[1];
  assign cnt_dec = cnt_q - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (!day_night) begin
      state_d = PedIdle;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        PedIdle: begin
          if (press) begin
            state_d = PedPending;
            pend_d  = 1'b1;
          end
        end
        PedPending: begin
          pend_d = 1'b1;
          if (grant_s) begin
            state_d = (WALK_TIME == 0) ? PedFlash : PedWalk;
            cnt_d   = LoadCnt;
            pend_d  = 1'b0;
          end
        end
        PedWalk, PedFlash: begin
          // A grant drop aborts the phase and overrides any tick on the same cycle.
          if (!grant_s) begin
            state_d = PedClear;
            cnt_d   = '0;
          end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_dec;
            if ((state_q == PedWalk) && (cnt_dec == FlashCnt)) begin
              state_d = PedFlash;
            end else if ((state_q == PedFlash) && (cnt_dec == '0)) begin
              state_d = PedClear;
            end
          end
        end
        PedClear: begin
          cnt_d = '0;
          if (press) begin
            pend_d = 1'b1;
          end
          if (!grant_s) begin
            state_d = (pend_q || press) ? PedPending : PedIdle;
          end
        end
        default: state_d = PedIdle;
      endcase
    end
  end

  always_ff @(posedge clk_fst or posedge rst) begin
    if (rst) begin
      cdn_q   <= '0;
      grant_q <= '0;
      state_q <= PedIdle;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      lamp_q  <= LampsOff;
    end else begin
      cdn_q   <= {cdn_q[1:0], clk_cnt_dn};
      grant_q <= {grant_q[0], ped_grant};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      lamp_q  <= lamps_for(state_d, day_night, cdn_s);
    end
  end

  assign ped_req       = lamp_q.ped_req;
  assign walk_led      = lamp_q.walk_led;
  assign dont_walk_led = lamp_q.dont_walk_led;
  assign walk_cnt      = cnt_q;
  assign req_pending   = pend_q;

endmodule

// File: tb/tb_ped_request_ctl.sv
// Bench for ped_request_ctl: a phase-level model checked every cycle plus directed scenarios.
module tb_ped_request_ctl;

  localparam int unsigned DebLen = 4;
  localparam int unsigned WalkT  = 10;
  localparam int unsigned FlashT = 5;
  localparam int unsigned CntW   = 8;

  logic            clk_fst = 1'b0;
  logic            rst = 1'b1;
  logic            day_night = 1'b1;
  logic            clk_cnt_dn = 1'b0;
  logic            btn_raw = 1'b0;
  logic            ped_grant = 1'b0;
  logic            ped_req, walk_led, dont_walk_led, req_pending;
  logic [CntW-1:0] walk_cnt;

  int checks = 0;
  int errors = 0;

  ped_request_ctl #(
    .DEB_LEN   (DebLen),
    .WALK_TIME (WalkT),
    .FLASH_TIME(FlashT),
    .CNT_W     (CntW)
  ) dut (
    .clk_fst      (clk_fst),
    .rst          (rst),
    .day_night    (day_night),
    .clk_cnt_dn   (clk_cnt_dn),
    .btn_raw      (btn_raw),
    .ped_grant    (ped_grant),
    .ped_req      (ped_req),
    .walk_led     (walk_led),
    .dont_walk_led(dont_walk_led),
    .walk_cnt     (walk_cnt),
    .req_pending  (req_pending)
  );

  always #5 clk_fst = ~clk_fst;

  // Slow count-down clock: 8 fast cycles per period.
  initial begin
    forever begin
      repeat (4) @(posedge clk_fst);
      #2 clk_cnt_dn = ~clk_cnt_dn;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Phase-level model: raw input histories per edge, crossing phase with remaining seconds.
  localparam int Idle = 0, Waiting = 1, Crossing = 2, Clearing = 3;
  logic bt_h [0:5];
  logic cd_h [0:2];
  logic g_h  [0:1];
  logic m_lvl, m_lvl_prev;
  int   m_phase, m_rem;
  logic m_pend, m_req, m_walk, m_dw;

  always @(posedge clk_fst or posedge rst) begin
    logic press, tick, cs, gs, all_diff;
    if (rst) begin
      for (int i = 0; i < 6; i++) bt_h[i] = 1'b0;
      for (int i = 0; i < 3; i++) cd_h[i] = 1'b0;
      for (int i = 0; i < 2; i++) g_h[i] = 1'b0;
      m_lvl = 1'b0; m_lvl_prev = 1'b0;
      m_phase = Idle; m_rem = 0; m_pend = 1'b0;
      m_req = 1'b0; m_walk = 1'b0; m_dw = 1'b1;
    end else begin
      press = m_lvl && !m_lvl_prev;
      tick  = cd_h[1] && !cd_h[2];
      cs    = cd_h[1];
      gs    = g_h[1];
      all_diff = 1'b1;
      for (int i = 1; i <= int'(DebLen); i++) if (bt_h[i] == m_lvl) all_diff = 1'b0;
      m_lvl_prev = m_lvl;
      if (all_diff) m_lvl = !m_lvl;
      if (!day_night) begin
        m_phase = Idle; m_rem = 0; m_pend = 1'b0;
      end else if (m_phase == Idle) begin
        if (press) begin m_phase = Waiting; m_pend = 1'b1; end
      end else if (m_phase == Waiting) begin
        if (gs) begin m_phase = Crossing; m_rem = WalkT + FlashT; m_pend = 1'b0; end
      end else if (m_phase == Crossing) begin
        if (!gs) begin
          m_phase = Clearing; m_rem = 0;
        end else if (tick && m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) m_phase = Clearing;
        end
      end else begin
        if (press) m_pend = 1'b1;
        if (!gs) m_phase = m_pend ? Waiting : Idle;
      end
      m_req  = (m_phase == Waiting) || (m_phase == Crossing);
      m_walk = (m_phase == Crossing) ? ((m_rem > int'(FlashT)) ? 1'b1 : cs) : 1'b0;
      m_dw   = !day_night ? cs : (m_phase != Crossing);
      for (int i = 5; i > 0; i--) bt_h[i] = bt_h[i-1];
      bt_h[0] = btn_raw;
      for (int i = 2; i > 0; i--) cd_h[i] = cd_h[i-1];
      cd_h[0] = clk_cnt_dn;
      g_h[1] = g_h[0];
      g_h[0] = ped_grant;
    end
  end

  always @(negedge clk_fst) begin
    check("ped_req", ped_req, m_req);
    check("walk_led", walk_led, m_walk);
    check("dont_walk_led", dont_walk_led, m_dw);
    check("walk_cnt", walk_cnt, m_rem);
    check("req_pending", req_pending, m_pend);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_fst);
    #2;
  endtask

  task automatic wait_cnt(input int val);
    int n = 0;
    while (int'(walk_cnt) != val && n < 400) begin step(1); n++; end
    check("wait_walk_cnt", walk_cnt, val);
  endtask

  task automatic wait_req(input logic val);
    int n = 0;
    while (ped_req != val && n < 400) begin step(1); n++; end
    check("wait_ped_req", ped_req, val);
  endtask

  task automatic push(input int hold);
    btn_raw = 1'b1; step(hold);
    btn_raw = 1'b0; step(8);
  endtask

  initial begin
    step(1);
    check("rst_ped_req", ped_req, 0);
    check("rst_dont_walk", dont_walk_led, 1);
    check("rst_walk_cnt", walk_cnt, 0);
    step(2);
    rst = 1'b0;
    step(4);

    // Bounce then hold: press lands six cycles after the hold starts.
    for (int i = 0; i < 6; i++) begin
      btn_raw = (i % 2 == 0);
      step(1);
    end
    btn_raw = 1'b1;
    step(6);
    check("bounce_early_req", ped_req, 0);
    step(1);
    check("bounce_req", ped_req, 1);
    check("bounce_pending", req_pending, 1);
    btn_raw = 1'b0;

    // Full walk cycle.
    step(3);
    ped_grant = 1'b1;
    step(2);
    check("grant_sync_cnt", walk_cnt, 0);
    step(1);
    check("load_cnt", walk_cnt, 15);
    check("load_walk_led", walk_led, 1);
    check("load_pending_cleared", req_pending, 0);
    wait_cnt(5);
    check("flash_dont_walk", dont_walk_led, 0);
    wait_req(1'b0);
    check("end_cnt", walk_cnt, 0);
    check("end_dont_walk", dont_walk_led, 1);
    ped_grant = 1'b0;
    step(4);
    check("idle_req", ped_req, 0);

    // Abort at walk_cnt = 8.
    push(8);
    check("abort_req_before", ped_req, 1);
    ped_grant = 1'b1;
    wait_cnt(8);
    ped_grant = 1'b0;
    step(3);
    check("abort_cnt", walk_cnt, 0);
    check("abort_dont_walk", dont_walk_led, 1);
    check("abort_req", ped_req, 0);
    step(4);

    // Re-arm: press in FLASH ignored, press in CLEAR latched.
    push(8);
    ped_grant = 1'b1;
    wait_cnt(3);
    btn_raw = 1'b1; step(8);
    check("flash_press_ignored", req_pending, 0);
    btn_raw = 1'b0; step(8);
    wait_req(1'b0);
    btn_raw = 1'b1; step(8);
    check("clear_press_pending", req_pending, 1);
    check("clear_req_low", ped_req, 0);
    btn_raw = 1'b0; step(8);
    ped_grant = 1'b0;
    step(4);
    check("rearm_req", ped_req, 1);

    // Night while PENDING.
    day_night = 1'b0;
    step(2);
    check("night_req", ped_req, 0);
    check("night_pending", req_pending, 0);
    step(16);
    btn_raw = 1'b1; step(10);
    day_night = 1'b1; step(10);
    check("night_press_ignored", ped_req, 0);
    btn_raw = 1'b0; step(8);

    // Reset in the middle of WALK.
    push(8);
    ped_grant = 1'b1;
    wait_cnt(12);
    #1 rst = 1'b1;
    #1;
    check("midrst_ped_req", ped_req, 0);
    check("midrst_walk_led", walk_led, 0);
    check("midrst_dont_walk", dont_walk_led, 1);
    check("midrst_walk_cnt", walk_cnt, 0);
    check("midrst_pending", req_pending, 0);
    step(2);
    rst = 1'b0;
    ped_grant = 1'b0;
    step(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
